// File: rtl/multi_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Contents: FSM state encoding and the default operand width.
package multi_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_BITS = 8;

endpackage

// File: rtl/multi_seq_datapath.sv
// Datapath of the sequential shift-add multiplier: operand registers,
// BITS+1-bit upper accumulator, add/shift step and the result register.
// Optional macro MULTI_SIGNED_MODE_EN adds two's-complement handling
// (magnitudes are multiplied, the product is negated on finish).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_load          latch operands, clear accumulator
//   i_step          perform one add/shift iteration
//   i_finish        last iteration: load o_product from the shifted value
//   i_a, i_b        operands (BITS bits)
//   i_signed        operands are two's complement (macro builds only)
//   o_product       registered 2*BITS-bit result
module multi_seq_datapath
  import multi_seq_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_finish,
  input  logic [BITS-1:0]   i_a,
  input  logic [BITS-1:0]   i_b,
`ifdef MULTI_SIGNED_MODE_EN
  input  logic              i_signed,
`endif
  output logic [2*BITS-1:0] o_product
);

  logic [BITS-1:0]   r_mcand;
  logic [BITS-1:0]   r_mult;
  logic [BITS:0]     r_acc;
  logic [2*BITS-1:0] r_product;

  logic [BITS-1:0]   w_a_mag;
  logic [BITS-1:0]   w_b_mag;
  logic [BITS-1:0]   w_addend;
  logic [BITS:0]     w_sum;
  logic [2*BITS-1:0] w_shifted;
  logic [2*BITS-1:0] w_result;

`ifdef MULTI_SIGNED_MODE_EN
  logic r_neg;

  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude 2^(BITS-1), so no extra bit is needed.
  assign w_a_mag  = (i_signed && i_a[BITS-1]) ? -i_a : i_a;
  assign w_b_mag  = (i_signed && i_b[BITS-1]) ? -i_b : i_b;
  assign w_result = r_neg ? -w_shifted : w_shifted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg <= 1'b0;
    end else if (i_load) begin
      r_neg <= i_signed && (i_a[BITS-1] ^ i_b[BITS-1]);
    end
  end
`else
  assign w_a_mag  = i_a;
  assign w_b_mag  = i_b;
  assign w_result = w_shifted;
`endif

  // One iteration: conditional add into the upper half (carry lands in the
  // extra accumulator bit), then {acc, mult} >> 1. The bit shifted out of
  // the accumulator enters the top of the multiplier register.
  assign w_addend  = r_mult[0] ? r_mcand : '0;
  assign w_sum     = r_acc + {1'b0, w_addend};
  assign w_shifted = {w_sum, r_mult[BITS-1:1]};

  // NOTE: every register here is small and gets an explicit async reset
  // value, so a mid-operation reset leaves no stale operand or result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand   <= '0;
      r_mult    <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update from the same pre-edge values.
      if (i_load) begin
        r_mcand <= w_a_mag;
        r_mult  <= w_b_mag;
        r_acc   <= '0;
      end else if (i_step) begin
        r_acc  <= {1'b0, w_shifted[2*BITS-1:BITS]};
        r_mult <= w_shifted[BITS-1:0];
      end
      if (i_finish) begin
        r_product <= w_result;
      end
    end
  end

  assign o_product = r_product;

endmodule

// File: rtl/multi_seq_nbits.sv
// Parametrised sequential shift-add multiplier, one multiplier bit per
// clock, with valid/ready handshakes on both operand input and result.
// Optional macro MULTI_SIGNED_MODE_EN adds port signed_i (two's complement).
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   A, B       operands, sampled on in_valid && in_ready
//   in_valid   operands valid
//   in_ready   block idle and able to accept operands
//   Product_o  2*BITS-bit result, held until the next result loads
//   out_valid  Product_o holds a new result
//   out_ready  consumer accepts the result
//   signed_i   operands are two's complement (macro builds only)
module multi_seq_nbits
  import multi_seq_pkg::*;
#(
  parameter  int BITS  = DEFAULT_BITS,
  localparam int CNT_W = $clog2(BITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS-1:0]   A,
  input  logic [BITS-1:0]   B,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2*BITS-1:0] Product_o,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MULTI_SIGNED_MODE_EN
  ,
  input  logic              signed_i
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would infer a latch.
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load = 1'b1;
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Both flags decode the registered state, so reset drops out_valid and
  // raises in_ready immediately.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  multi_seq_datapath #(
    .BITS(BITS)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_finish (w_finish),
    .i_a      (A),
    .i_b      (B),
`ifdef MULTI_SIGNED_MODE_EN
    .i_signed (signed_i),
`endif
    .o_product(Product_o)
  );

endmodule

// File: tb/tb_multi_seq_nbits.sv
// Self-checking bench for multi_seq_nbits: a BITS=4 and a BITS=8 instance
// run against a transaction-level reference model, plus literal checks.
module tb_multi_seq_nbits;

`ifdef MULTI_SIGNED_MODE_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [3:0]  a4 = '0, b4 = '0;
  logic        iv4 = 1'b0, or4 = 1'b1, sg4 = 1'b0;
  logic        ir4, ov4;
  logic [7:0]  p4;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        iv8 = 1'b0, or8 = 1'b1, sg8 = 1'b0;
  logic        ir8, ov8;
  logic [15:0] p8;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  multi_seq_nbits #(.BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .in_valid(iv4), .in_ready(ir4),
    .Product_o(p4), .out_valid(ov4), .out_ready(or4)
`ifdef MULTI_SIGNED_MODE_EN
    , .signed_i(sg4)
`endif
  );

  multi_seq_nbits #(.BITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(iv8), .in_ready(ir8),
    .Product_o(p8), .out_valid(ov8), .out_ready(or8)
`ifdef MULTI_SIGNED_MODE_EN
    , .signed_i(sg8)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact product of the operands taken as integers, reduced to
  // 2*bits bits (two's complement wrap for negative signed products).
  function automatic longint ref_prod(int bits, int a, int b, logic sg);
    longint sa, sb, p;
    sa = a;
    sb = b;
    if (sg) begin
      if (sa >= (longint'(1) << (bits - 1))) sa -= longint'(1) << bits;
      if (sb >= (longint'(1) << (bits - 1))) sb -= longint'(1) << bits;
    end
    p = sa * sb;
    return p & ((longint'(1) << (2 * bits)) - 1);
  endfunction

  // Transaction model per instance: 0 = accepting, 1 = busy, 2 = holding.
  // An accepted operation becomes visible exactly `bits` edges later.
  int     m_st[2]   = '{0, 0};
  int     m_left[2] = '{0, 0};
  longint m_pend[2] = '{0, 0};
  longint m_prod[2] = '{0, 0};

  task automatic model_edge(input int k, input int bits, input logic iv,
                            input logic ordy, input int a, input int b,
                            input logic sg);
    case (m_st[k])
      0: if (iv) begin
        m_pend[k] = ref_prod(bits, a, b, sg);
        m_left[k] = bits;
        m_st[k]   = 1;
      end
      1: begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_st[k]   = 2;
          m_prod[k] = m_pend[k];
        end
      end
      default: if (ordy) m_st[k] = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k]   = 0;
        m_left[k] = 0;
        m_prod[k] = 0;
      end
    end else begin
      model_edge(0, 4, iv4, or4, int'(a4), int'(b4), SIGNED_EN && sg4);
      model_edge(1, 8, iv8, or8, int'(a8), int'(b8), SIGNED_EN && sg8);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc in_ready4",  ir4, longint'(m_st[0] == 0));
      check("cyc out_valid4", ov4, longint'(m_st[0] == 2));
      check("cyc product4",   p4,  m_prod[0]);
      check("cyc in_ready8",  ir8, longint'(m_st[1] == 0));
      check("cyc out_valid8", ov8, longint'(m_st[1] == 2));
      check("cyc product8",   p8,  m_prod[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One operation on the BITS=4 instance with out_ready high; checks the
  // literal result exactly 4 edges after the accepting edge.
  task automatic run4(input string nm, input logic [3:0] a, input logic [3:0] b,
                      input logic sg, input logic [7:0] exp);
    a4 = a; b4 = b; sg4 = sg; iv4 = 1'b1; or4 = 1'b1;
    tick();
    iv4 = 1'b0;
    repeat (3) begin
      tick();
      check({nm, " busy in_ready"}, ir4, 0);
    end
    tick();
    check({nm, " out_valid"}, ov4, 1);
    check({nm, " product"}, p4, exp);
    check({nm, " done in_ready"}, ir4, 0);
    tick();
  endtask

  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    a8 = a; b8 = b; sg8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (7) tick();
    check({nm, " early out_valid"}, ov8, 0);
    tick();
    check({nm, " out_valid"}, ov8, 1);
    check({nm, " product"}, p8, exp);
    tick();
  endtask

  initial begin
    int rise_cyc[$];
    longint rise_val[$];
    logic prev;

    repeat (2) tick();
    chk_en = 1'b1;
    check("reset product4", p4, 0);
    check("reset out_valid4", ov4, 0);
    check("reset in_ready4", ir4, 1);
    check("reset product8", p8, 0);
    rst = 1'b1;
    tick();

    // Test 1: 15*15 on BITS=4.
    run4("t1 15*15", 4'd15, 4'd15, 1'b0, 8'd225);

    // Test 2: zero operand takes full latency, then max*max on BITS=8.
    run8("t2 0*200", 8'd0, 8'd200, 16'd0);
    run8("t2 255*255", 8'd255, 8'd255, 16'd65025);

    // Test 3: in_valid held high, operands change right after acceptance.
    a4 = 4'd3; b4 = 4'd5; iv4 = 1'b1; or4 = 1'b1;
    tick();
    a4 = 4'd7; b4 = 4'd9;
    prev = ov4;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (ov4 && !prev) begin
        rise_cyc.push_back(i);
        rise_val.push_back(longint'(p4));
      end
      prev = ov4;
    end
    iv4 = 1'b0;
    check("t3 result count", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2) begin
      check("t3 first result", rise_val[0], 15);
      check("t3 second result", rise_val[1], 63);
      check("t3 spacing", rise_cyc[1] - rise_cyc[0], 6);
    end
    repeat (2) tick();

    // Test 4: backpressure on BITS=8 for 20 cycles.
    a8 = 8'd13; b8 = 8'd17; iv8 = 1'b1; or8 = 1'b0;
    tick();
    iv8 = 1'b0;
    repeat (8) tick();
    check("t4 out_valid", ov8, 1);
    check("t4 product", p8, 221);
    repeat (20) tick();
    check("t4 held out_valid", ov8, 1);
    check("t4 held product", p8, 221);
    or8 = 1'b1;
    tick();
    check("t4 release out_valid", ov8, 0);
    check("t4 release in_ready", ir8, 1);
    check("t4 kept product", p8, 221);

    // Test 5: reset during the second calculation cycle of 12*11.
    a4 = 4'd12; b4 = 4'd11; iv4 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t5 rst out_valid", ov4, 0);
    check("t5 rst product", p4, 0);
    check("t5 rst in_ready", ir4, 1);
    tick();
    tick();
    iv4 = 1'b0;
    rst = 1'b1;
    repeat (8) tick();
    check("t5 no stale out_valid", ov4, 0);
    check("t5 no stale product", p4, 0);

`ifdef MULTI_SIGNED_MODE_EN
    // Test 6: signed mode on BITS=4.
    run4("t6 -8*7", 4'h8, 4'd7, 1'b1, 8'hC8);
    run4("t6 -8*-8", 4'h8, 4'h8, 1'b1, 8'd64);
    run4("t6 u8*7", 4'h8, 4'd7, 1'b0, 8'd56);
    run4("t6 u8*8", 4'h8, 4'h8, 1'b0, 8'd64);
`endif

    run4("t7 5*3", 4'd5, 4'd3, 1'b0, 8'd15);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_seq_nbits.md
Name: multi_seq_nbits

Overview:
Parametrised sequential shift-add multiplier; successor to the fixed 4-bit combinational multiplier.
- Computes a 2*BITS-bit product of two BITS-bit operands, one multiplier bit per clock.
- Operands enter and the product leaves through valid/ready handshakes, so the block can sit between pipelined producers and consumers in the top-level wrapper.

Parameters:
- BITS, 8, operand width; legal range >= 2.
- CNT_W, $clog2(BITS+1), iteration counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset. Assert low to reset; deassert synchronously to clk.
- A  input  BITS  multiplicand; sampled on input handshake.
- B  input  BITS  multiplier; sampled on input handshake.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- Product_o  output  2*BITS  result; stable while out_valid=1.
- out_valid  output  1  Product_o holds a new result.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (rst low, asynchronous): state=S_IDLE, Product_o=0, out_valid=0, accumulator=0, counter=0.
  - in_ready = (state==S_IDLE), so it is 1 during reset.
  - in_valid is ignored while rst is low.
- FSM states: S_IDLE, S_CALC, S_DONE.
- S_IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A into the multiplicand register and B into the multiplier shift register; clear the BITS+1-bit upper accumulator; counter=0; go to S_CALC.
- S_CALC (exactly BITS cycles; in_ready=0):
  - If the multiplier LSB is 1: upper_acc += multiplicand, with carry kept in the extra bit.
  - Then shift {upper_acc, mult} right by 1.
  - counter++. When counter==BITS-1, go to S_DONE on the same edge and load Product_o from the final shifted value.
- S_DONE:
  - out_valid=1, in_ready=0.
  - Product_o must not change while out_valid=1 && !out_ready. out_ready may be held low indefinitely.
  - On out_ready: out_valid=0 and go to S_IDLE.
- Latency: if operands are accepted on edge t, out_valid is high after edge t+BITS.
- Throughput: one result every BITS+2 cycles. There is one S_IDLE bubble after each result; no same-cycle result/accept overlap.
- Product_o keeps the last result after out_valid drops, until the next result loads.
- Arithmetic: unsigned, exact, no truncation. Max (2^BITS-1)^2 fits in 2*BITS bits.
- Zero operands take the full BITS cycles; no early termination.
- Reset mid-operation (S_CALC or S_DONE): the result is discarded with no partial out_valid pulse. After reset deassertion the block is back in S_IDLE.
- A/B changes after the handshake have no effect.

Optional Feature:
- Macro: MULTI_SIGNED_MODE_EN.
- Defined:
  - Adds input port signed_i (1 bit), sampled on the input handshake.
  - When signed_i=1, A and B are two's complement. The block multiplies the magnitudes and negates the product on entry to S_DONE if the operand signs differ.
  - Most-negative operand: magnitude 2^(BITS-1) must be handled correctly, e.g. BITS=4: -8*-8 = +64.
  - Latency is unchanged.
- Undefined: no signed_i port; behaviour is purely unsigned as above.

Decomposition:
- Package multi_seq_pkg:
  - state_t enum {S_IDLE, S_CALC, S_DONE}, 2-bit encoding.
  - DEFAULT_BITS=8 constant.
- Natural split:
  - multi_seq_nbits: FSM, handshakes, counter.
  - Sub-module multi_seq_datapath: operand registers, accumulator, add/shift, optional sign correction; controlled by load/step/finish strobes.

Test Plan:
1. BITS=4: A=15, B=15, out_ready=1 -> out_valid after 4 edges, Product_o=225; in_ready low during S_CALC/S_DONE.
2. BITS=8: A=0, B=200 -> Product_o=0 after 8 cycles. Then A=255, B=255 -> 65025.
3. Back-to-back, in_valid held high with streaming operands 3*5 then 7*9 -> results 15, 63 in order; spacing BITS+2 cycles.
4. Backpressure: out_ready=0 for 20 cycles in S_DONE -> out_valid and Product_o stay constant; the cycle after out_ready=1, out_valid=0 and in_ready=1.
5. Reset mid-op: accept 12*11 (BITS=4), pull rst low during the 2nd S_CALC cycle -> out_valid=0, Product_o=0, in_ready=1 immediately; no stale result after release.
6. MULTI_SIGNED_MODE_EN, BITS=4, signed_i=1:
   - -8*7 -> 8'hC8 (-56).
   - -8*-8 -> 64.
   - Same operands with signed_i=0: 8*7=56, 8*8=64.
